// File: rtl/pb_pkg.sv
// Shared types and default timing for the push-button event decoder.
// Imported by pb_press_decoder.
package pb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        DB_RELEASE = 3'd4
    } pb_state_t;

    localparam int DB_CYCLES_DEF     = 50_000;
    localparam int LONG_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer, preset to 1 on reset (idle-high input).
// Ports: clk, rst_n (async, active-low), d (async in), q (synced out).
module pb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pb_press_decoder.sv
// Debounced push-button decoder: press/release, short/long, auto-repeat.
// Ports: clk, rst_n, PB (raw, active-low); pressed level and 1-cycle
// strobes press, release_pulse, short_press, long_press, repeat_pulse.
module pb_press_decoder
    import pb_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB,
    output logic pressed,
    output logic press,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse
);

    // Guard against zero-width counters for tiny parameter values.
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HL_W  = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam int RP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [HL_W-1:0] HL_LAST = HL_W'(LONG_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic pb_s;

    pb_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (PB),
        .q     (pb_s)
    );

    pb_state_t       state_q, state_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [HL_W-1:0] hold_q, hold_d;
    logic [RP_W-1:0] rep_q, rep_d;
    logic            long_q, long_d;
    logic            pressed_d, press_d, rel_d;
    logic            short_d, lp_d, rpt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            db_q          <= '0;
            hold_q        <= '0;
            rep_q         <= '0;
            long_q        <= 1'b0;
            pressed       <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state_q       <= state_d;
            db_q          <= db_d;
            hold_q        <= hold_d;
            rep_q         <= rep_d;
            long_q        <= long_d;
            pressed       <= pressed_d;
            press         <= press_d;
            release_pulse <= rel_d;
            short_press   <= short_d;
            long_press    <= lp_d;
            repeat_pulse  <= rpt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        long_d    = long_q;
        pressed_d = pressed;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        short_d   = 1'b0;
        lp_d      = 1'b0;
        rpt_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!pb_s) begin
                    state_d = DB_PRESS;
                    db_d    = '0;
                end
            end
            DB_PRESS: begin
                if (pb_s) begin
                    state_d = IDLE;
                end else if (db_q == DB_LAST) begin
                    state_d   = HELD;
                    press_d   = 1'b1;
                    pressed_d = 1'b1;
                    hold_d    = '0;
                    long_d    = 1'b0;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            HELD: begin
                // Release sampling wins; hold_cnt freezes until resolved.
                if (pb_s) begin
                    state_d = DB_RELEASE;
                    db_d    = '0;
                end else if (hold_q == HL_LAST) begin
                    state_d = LONG_HELD;
                    lp_d    = 1'b1;
                    long_d  = 1'b1;
                    rep_d   = '0;
                end else begin
                    hold_d = hold_q + HL_W'(1);
                end
            end
            LONG_HELD: begin
                if (pb_s) begin
                    state_d = DB_RELEASE;
                    db_d    = '0;
                end else if (rep_q == RP_LAST) begin
                    rpt_d = 1'b1;
                    rep_d = '0;
                end else begin
                    rep_d = rep_q + RP_W'(1);
                end
            end
            DB_RELEASE: begin
                // A bounce back low resumes the hold without any strobe.
                if (!pb_s) begin
                    state_d = long_q ? LONG_HELD : HELD;
                end else if (db_q == DB_LAST) begin
                    state_d   = IDLE;
                    rel_d     = 1'b1;
                    short_d   = !long_q;
                    pressed_d = 1'b0;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pb_press_decoder.sv
// Directed self-checking bench for pb_press_decoder.
// Small timing parameters: DB=4, LONG=20, REPEAT=5.
module tb_pb_press_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic PB = 1'b1;
    logic pressed, press, release_pulse;
    logic short_press, long_press, repeat_pulse;

    int tests = 0;
    int fails = 0;

    pb_press_decoder #(
        .DB_CYCLES     (4),
        .LONG_CYCLES   (20),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PB            (PB),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {pressed, press, release_pulse,
                short_press, long_press, repeat_pulse};
    endfunction

    // Expected {pressed,press,release,short,long,repeat} at edge e.
    // Zero means "no such event" for any edge argument.
    function automatic logic [5:0] ev(
        int e, int p, int r, bit sh, int l, int r1, int r2);
        logic [5:0] v;
        v[5] = (p > 0) && (e >= p) && ((r == 0) || (e < r));
        v[4] = (p > 0) && (e == p);
        v[3] = (r > 0) && (e == r);
        v[2] = sh && (r > 0) && (e == r);
        v[1] = (l > 0) && (e == l);
        v[0] = ((r1 > 0) && (e == r1)) || ((r2 > 0) && (e == r2));
        return v;
    endfunction

    task automatic chk(string tag, logic [5:0] got, logic [5:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive PB away from the active edge, then sample 1 ns after it.
    task automatic tick(logic pb_v, logic [5:0] exp, string tag, int e);
        @(negedge clk);
        PB = pb_v;
        @(posedge clk);
        #1;
        chk($sformatf("%s@%0d", tag, e), outs(), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset", outs(), 6'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Short press: PB high sampled at edge 12.
        for (int e = 1; e <= 24; e++)
            tick(e >= 12, ev(e, 7, 18, 1, 0, 0, 0), "short", e);

        // Glitch: three low samples only.
        for (int e = 1; e <= 15; e++)
            tick(e >= 4, ev(e, 0, 0, 0, 0, 0, 0), "glitch", e);

        // Long press with two repeats.
        for (int e = 1; e <= 50; e++)
            tick(e >= 38, ev(e, 7, 44, 0, 27, 32, 37), "long", e);

        // Release bounce: high 12-13, low 14, high from 15.
        for (int e = 1; e <= 30; e++)
            tick(!(e <= 11 || e == 14),
                 ev(e, 7, 21, 1, 0, 0, 0), "bounce", e);

        // Reset while in HELD with PB low.
        for (int e = 1; e <= 10; e++)
            tick(1'b0, ev(e, 7, 0, 0, 0, 0, 0), "prehold", e);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 6'b0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("reset_hold", outs(), 6'b0);
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 25; e++)
            tick(e >= 12, ev(e, 7, 18, 1, 0, 0, 0), "rst_hold", e);

        // Two taps separated by 6 high cycles.
        for (int e = 1; e <= 40; e++)
            tick(!(e <= 11 || (e >= 18 && e <= 28)),
                 ev(e, 7, 18, 1, 0, 0, 0) |
                 ev(e, 24, 35, 1, 0, 0, 0), "taps", e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
